// File: rtl/pico_music_pkg.sv
// Shared definitions for the tone generator family: sequencer state
// encoding and the period threshold below which a note is a rest.
package pico_music_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_GAP  = 2'd3
   } tone_state_e;

   // Any period shorter than this cannot form a square wave and is silent.
   localparam logic [31:0] REST_PERIOD_MIN = 32'd2;

   function automatic logic is_rest(input logic [31:0] period);
      return (period < REST_PERIOD_MIN);
   endfunction

endpackage

// File: rtl/pico_tone_gen_if.sv
// Note request channel: a producer offers one note (ROM index plus
// duration in ms) and the tone generator signals when it can take it.
interface pico_tone_gen_if;
   logic        note_valid;
   logic [3:0]  note_idx;
   logic [15:0] dur_ms;
   logic        note_ready;

   modport master (
      output note_valid,
      output note_idx,
      output dur_ms,
      input  note_ready
   );

   modport slave (
      input  note_valid,
      input  note_idx,
      input  dur_ms,
      output note_ready
   );
endinterface

// File: rtl/pico_ms_timer.sv
// Millisecond timebase: a prescaler counting 0..CLK_PER_MS-1 feeding a
// 16-bit ms counter. ms_tick marks the last clock of each millisecond so
// a caller can end an interval exactly on a ms boundary.
module pico_ms_timer #(
   parameter int unsigned CLK_PER_MS = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        en,
   output logic [15:0] ms_count,
   output logic        ms_tick
);

   localparam int unsigned   PW       = (CLK_PER_MS > 32'd1) ? $clog2(CLK_PER_MS) : 32'd1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 32'd1);

   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   ms_q, ms_d;

   // Next-state for prescaler and ms counter; clear wins over counting.
   always_comb begin
      pre_d = pre_q;
      ms_d  = ms_q;
      if (clr) begin
         pre_d = '0;
         ms_d  = 16'd0;
      end else if (en) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            ms_d  = ms_q + 16'd1;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end else begin
         pre_d = pre_q;
         ms_d  = ms_q;
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q <= '0;
         ms_q  <= 16'd0;
      end else begin
         pre_q <= pre_d;
         ms_q  <= ms_d;
      end
   end

   assign ms_count = ms_q;
   assign ms_tick  = en && (pre_q == PRE_LAST);

endmodule

// File: rtl/pico_tone_gen.sv
// Square-wave note player. Accepts one note at a time, looks up its full
// period in an external combinational ROM, plays it for dur_ms ms and
// pulses done at the end. Periods below 2 clocks are rests (silence).
// Optional feature macro PICO_TONE_GAP_EN: insert a silent GAP_MS gap
// after every note before the next one can be accepted.
module pico_tone_gen
   import pico_music_pkg::*;
#(
   parameter int unsigned CLK_PER_MS = 50000,
   parameter int unsigned GAP_MS     = 20
) (
   input  logic           clk,
   input  logic           reset,
   pico_tone_gen_if.slave note,
   output logic [3:0]     rom_addr,
   input  logic [31:0]    rom_data,
   output logic           tone_out,
   output logic           busy,
   output logic           done
);

   tone_state_e state_q;
   logic        note_ready_q;
   logic        tone_q;
   logic        done_q;
   logic        busy_q;
   logic [3:0]  rom_addr_q;
   logic [15:0] dur_q;
   logic [31:0] half_q;
   logic [31:0] tcnt_q;
   logic        rest_q;

   logic        tmr_clr_s;
   logic        tmr_en_s;
   logic        ms_tick_s;
   logic [15:0] ms_count_s;
   logic        play_end_s;
   logic        end_note_s;

   pico_ms_timer #(
      .CLK_PER_MS (CLK_PER_MS)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr      (tmr_clr_s),
      .en       (tmr_en_s),
      .ms_count (ms_count_s),
      .ms_tick  (ms_tick_s)
   );

`ifdef PICO_TONE_GAP_EN
   logic gap_end_s;
   assign gap_end_s = (GAP_MS == 32'd0) ||
                      (ms_tick_s && (ms_count_s == 16'(GAP_MS - 32'd1)));
`else
   logic unused_gap_s;
   assign unused_gap_s = (GAP_MS == 32'd0);
`endif

   // End-of-note detection and timer control; the timer restarts at the
   // start of PLAY and again at the start of the gap.
   always_comb begin
      if (state_q == ST_PLAY) begin
         play_end_s = ms_tick_s && (ms_count_s == (dur_q - 16'd1));
      end else begin
         play_end_s = 1'b0;
      end
      end_note_s = ((state_q == ST_LOAD) && (dur_q == 16'd0)) || play_end_s;
      tmr_en_s   = (state_q == ST_PLAY) || (state_q == ST_GAP);
      tmr_clr_s  = (state_q == ST_LOAD) || end_note_s;
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         note_ready_q <= 1'b1;
         tone_q       <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         rom_addr_q   <= 4'd0;
         dur_q        <= 16'd0;
         half_q       <= 32'd0;
         tcnt_q       <= 32'd0;
         rest_q       <= 1'b0;
      end else if (end_note_s) begin
         done_q <= 1'b1;
         tone_q <= 1'b0;
         tcnt_q <= 32'd0;
`ifdef PICO_TONE_GAP_EN
         state_q      <= ST_GAP;
         note_ready_q <= 1'b0;
         busy_q       <= 1'b1;
`else
         state_q      <= ST_IDLE;
         note_ready_q <= 1'b1;
         busy_q       <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tone_q <= 1'b0;
               if (note.note_valid && note_ready_q) begin
                  rom_addr_q   <= note.note_idx;
                  dur_q        <= note.dur_ms;
                  state_q      <= ST_LOAD;
                  note_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
               end else begin
                  note_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
               end
            end
            ST_LOAD: begin
               // dur_ms == 0 never gets here: it ends the note above.
               half_q  <= {1'b0, rom_data[31:1]};
               rest_q  <= is_rest(rom_data);
               tcnt_q  <= 32'd0;
               tone_q  <= ~is_rest(rom_data);
               state_q <= ST_PLAY;
            end
            ST_PLAY: begin
               if (rest_q) begin
                  tone_q <= 1'b0;
               end else if (tcnt_q == (half_q - 32'd1)) begin
                  tone_q <= ~tone_q;
                  tcnt_q <= 32'd0;
               end else begin
                  tcnt_q <= tcnt_q + 32'd1;
               end
            end
            ST_GAP: begin
               tone_q <= 1'b0;
`ifdef PICO_TONE_GAP_EN
               if (gap_end_s) begin
                  state_q      <= ST_IDLE;
                  note_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  state_q <= ST_GAP;
               end
`else
               state_q      <= ST_IDLE;
               note_ready_q <= 1'b1;
               busy_q       <= 1'b0;
`endif
            end
            default: begin
               state_q      <= ST_IDLE;
               note_ready_q <= 1'b1;
               busy_q       <= 1'b0;
               tone_q       <= 1'b0;
            end
         endcase
      end
   end

   assign note.note_ready = note_ready_q;
   assign rom_addr        = rom_addr_q;
   assign tone_out        = tone_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_pico_tone_gen.sv
// Directed bench for pico_tone_gen with CLK_PER_MS=10 and a stub ROM.
// A timeline model (cycles since acceptance) predicts every output each
// cycle; directed note tasks add hand-computed totals per note.
module tb_pico_tone_gen;

   localparam int C     = 10;
   localparam int GAPMS = 1;
`ifdef PICO_TONE_GAP_EN
   localparam int G = GAPMS * C;
`else
   localparam int G = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  rom_addr;
   logic [31:0] rom_data;
   logic        tone_out, busy, done;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   pico_tone_gen_if nif();

   pico_tone_gen #(.CLK_PER_MS(C), .GAP_MS(GAPMS)) dut (
      .clk      (clk),
      .reset    (reset),
      .note     (nif),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .tone_out (tone_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_tab(input logic [3:0] a);
      case (a)
         4'd0:    return 32'd10;
         4'd1:    return 32'd1;
         4'd2:    return 32'd4;
         4'd3:    return 32'd7;
         4'd4:    return 32'd0;
         4'd5:    return 32'd2;
         default: return 32'd10;
      endcase
   endfunction

   assign rom_data = rom_tab(rom_addr);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Timeline model: m_t counts cycles since acceptance (1 = ROM lookup,
   // 2..1+P playing, then done, then G silent gap cycles).
   bit         m_active = 1'b0;
   bit         m_done   = 1'b0;
   int         m_t      = 0;
   int         m_p      = 0;
   int         m_half   = 0;
   bit         m_rest   = 1'b0;
   logic [3:0] m_idx    = 4'd0;

   always @(posedge clk) begin
      if (reset) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_idx    <= 4'd0;
      end else if (!m_active) begin
         m_done <= 1'b0;
         if (nif.note_valid) begin
            m_active <= 1'b1;
            m_t      <= 1;
            m_idx    <= nif.note_idx;
            m_p      <= int'(nif.dur_ms) * C;
            m_half   <= int'(rom_tab(nif.note_idx)) / 2;
            m_rest   <= (rom_tab(nif.note_idx) < 32'd2);
         end
      end else if (m_t == 1 + m_p) begin
         m_done <= 1'b1;
         if (G > 0) m_t <= m_t + 1;
         else       m_active <= 1'b0;
      end else if (m_t >= 1 + m_p + G) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
      end else begin
         m_t    <= m_t + 1;
         m_done <= 1'b0;
      end
   end

   bit e_tone, e_busy, e_ready;

   // Per-cycle compare of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         if (!m_active) begin
            e_ready = 1'b1; e_busy = 1'b0; e_tone = 1'b0;
         end else if (m_t == 1) begin
            e_ready = 1'b0; e_busy = 1'b1; e_tone = 1'b0;
         end else if (m_t <= 1 + m_p) begin
            e_ready = 1'b0; e_busy = 1'b1;
            if (m_rest) e_tone = 1'b0;
            else        e_tone = (((m_t - 2) / m_half) % 2) == 0;
         end else begin
            e_ready = 1'b0; e_busy = 1'b1; e_tone = 1'b0;
         end
         check("model_tone", tone_out, e_tone);
         check("model_done", done, m_done);
         check("model_busy", busy, e_busy);
         check("model_ready", nif.note_ready, e_ready);
         check("model_rom_addr", rom_addr, m_idx);
      end
   end

   // Play one note and check per-note totals; poke pulses a request mid-note.
   task automatic play_note(input logic [3:0] idx, input logic [15:0] dur,
                            input int exp_high, input int exp_busy,
                            input int exp_done_at, input bit poke);
      int hi = 0, bc = 0, dc = 0, dat = 0;
      bit fin = 1'b0;
      @(negedge clk);
      nif.note_valid = 1'b1; nif.note_idx = idx; nif.dur_ms = dur;
      @(negedge clk);
      nif.note_valid = 1'b0;
      for (int i = 1; i <= 2000 && !fin; i++) begin
         if (i > 1) @(negedge clk);
         if (poke && i == 5) begin
            nif.note_valid = 1'b1; nif.note_idx = 4'd9;
         end else if (poke && i == 6) begin
            nif.note_valid = 1'b0;
         end
         if (busy) bc++;
         if (tone_out) hi++;
         if (done) begin dc++; dat = i; end
         if (!busy) fin = 1'b1;
      end
      check("note_end_seen", fin, 1);
      check("high_cycles", hi, exp_high);
      check("busy_cycles", bc, exp_busy);
      check("done_count", dc, 1);
      check("done_at", dat, exp_done_at);
   endtask

   initial begin
      int dcnt;
      bit fin;
      nif.note_valid = 1'b0; nif.note_idx = 4'd0; nif.dur_ms = 16'd0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;
      check("reset_ready", nif.note_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_tone", tone_out, 0);
      check("reset_done", done, 0);
      check("reset_rom_addr", rom_addr, 0);

      // period 10, 3 ms: toggles every 5 cycles, 30 play cycles
      play_note(4'd0, 16'd3, 15, 31 + G, 32, 1'b1);
      // ROM value 1 is a rest
      play_note(4'd1, 16'd2, 0, 21 + G, 22, 1'b0);
      // zero duration: done right after lookup
      play_note(4'd2, 16'd0, 0, 1 + G, 2, 1'b0);
      // period 7 -> half 3: HHHLLLHHHL
      play_note(4'd3, 16'd1, 6, 11 + G, 12, 1'b0);
      // period 2 -> half 1: alternating
      play_note(4'd5, 16'd1, 5, 11 + G, 12, 1'b0);
      // period 0 is a rest
      play_note(4'd4, 16'd1, 0, 11 + G, 12, 1'b0);

      // request held high: one accept per idle visit
      @(negedge clk);
      nif.note_valid = 1'b1; nif.note_idx = 4'd0; nif.dur_ms = 16'd1;
      dcnt = 0;
      for (int i = 1; i <= 48; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      nif.note_valid = 1'b0;
      check("held_done_count", dcnt, (G > 0) ? 2 : 4);
      fin = 1'b0;
      for (int i = 0; i < 200 && !fin; i++) begin
         @(negedge clk);
         if (!busy) fin = 1'b1;
      end
      check("held_drain", fin, 1);

      // reset during play cycle 12 (tone is high there)
      @(negedge clk);
      nif.note_valid = 1'b1; nif.note_idx = 4'd0; nif.dur_ms = 16'd3;
      @(negedge clk);
      nif.note_valid = 1'b0;
      repeat (13) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_tone", tone_out, 0);
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      check("midreset_ready", nif.note_ready, 1);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("midreset_no_done", dcnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pico_tone_gen.md
PICO_TONE_GEN -- requirements
Module: pico_tone_gen

Interface
REQ-001 SHALL have parameter CLK_PER_MS, default 50000, clock cycles per millisecond (50 MHz).
REQ-002 SHALL have parameter GAP_MS, default 20, silent gap in ms between notes (used only when the gap feature is compiled in).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port note_valid  input  1  note request present.
REQ-006 SHALL have port note_idx  input  4  note index, used as the period-ROM address.
REQ-007 SHALL have port dur_ms  input  16  note duration in ms.
REQ-008 SHALL have port note_ready  output  1  block can accept a note.
REQ-009 SHALL have port rom_addr  output  4  address to the 16x32 period ROM.
REQ-010 SHALL have port rom_data  input  32  ROM output: full tone period in clk cycles (combinational ROM).
REQ-011 SHALL have port tone_out  output  1  square-wave audio output.
REQ-012 SHALL have port busy  output  1  note loading, playing or in gap.
REQ-013 SHALL have port done  output  1  one-cycle pulse at the end of each note.

Function
REQ-014 SHALL use a registered FSM with states IDLE, LOAD, PLAY, GAP.
REQ-015 SHALL assert note_ready only in IDLE; a note is accepted on a clk edge where note_valid && note_ready.
REQ-016 On acceptance SHALL register note_idx into rom_addr and dur_ms into a duration register, then go IDLE->LOAD.
REQ-017 In LOAD (one cycle) SHALL capture rom_data, set half = rom_data>>1, clear the counters, then go LOAD->PLAY.
REQ-018 SHALL treat a captured period < 2 (e.g. ROM value 1) as a rest: tone_out held 0 for the full duration.
REQ-019 For a non-rest note, SHALL drive tone_out to 1 on the LOAD->PLAY edge and toggle it every half cycles while in PLAY.
REQ-020 SHALL accumulate duration with a ms-tick prescaler counting 0..CLK_PER_MS-1 and a 16-bit ms counter; PLAY SHALL last exactly dur_ms*CLK_PER_MS cycles.
REQ-021 SHALL, if dur_ms == 0, spend zero cycles in PLAY: LOAD exits straight to the end-of-note action.
REQ-022 At end of note SHALL pulse done for exactly one cycle and force tone_out to 0 in the same cycle.
REQ-023 SHALL drive busy = (state != IDLE).
REQ-024 SHALL ignore note_valid while not in IDLE; no request is queued.
REQ-025 SHALL use counter widths sufficient for the largest 32-bit period and for CLK_PER_MS; the toggle compare is on the current half value.

Reset
REQ-026 Reset SHALL take precedence over all other inputs, including reset mid-PLAY or mid-GAP.
REQ-027 On reset SHALL set state=IDLE, note_ready=1 in the following cycle, tone_out=0, done=0, busy=0, rom_addr=0 and all counters=0.

Configuration
REQ-028 With PICO_TONE_GAP_EN defined, end of PLAY SHALL go to GAP with done asserted on PLAY exit, hold tone_out=0 for GAP_MS*CLK_PER_MS cycles, then go to IDLE.
REQ-029 Without PICO_TONE_GAP_EN, end of PLAY SHALL go directly to IDLE with done asserted, and GAP logic and GAP_MS SHALL be unused.

Structure
REQ-030 SHALL take the state encoding and the rest threshold (2) from shared package pico_music_pkg.
REQ-031 SHALL implement the prescaler plus ms counter as sub-module pico_ms_timer (inputs clr and en; output ms_count), which is reused by the sequencer.
REQ-032 SHALL NOT embed the ROM; the existing period ROM is instantiated beside this block.

Verification (all scenarios with CLK_PER_MS=10 and a stub ROM)
REQ-033 Stub returns 10, dur_ms=3 -> tone_out toggles every 5 cycles, PLAY lasts 30 cycles, then done pulses once and tone_out=0.
REQ-034 Stub returns 1 (rest), dur_ms=2 -> tone_out stays 0 for 20 cycles, then done pulses once.
REQ-035 dur_ms=0 -> done pulses on the cycle after LOAD and tone_out never rises.
REQ-036 note_valid held high through a note -> exactly one accept per IDLE visit; a second note is accepted only after done.
REQ-037 reset asserted at cycle 12 of PLAY -> next cycle state=IDLE, tone_out=0, busy=0, no done pulse.
REQ-038 PICO_TONE_GAP_EN defined, GAP_MS=1 -> after done, 10 silent cycles with busy=1 and note_ready=0, then note_ready=1.
